// File: rtl/bme_spi_pkg.sv
// -----------------------------------------------------------------------------
// bme_spi_pkg
// Shared definitions for the BME280 burst reader:
//   state_t     - burst sequencer states
//   READ_BIT    - address bit 7, set for register reads on the SPI wire
//   PRESS_MSB / TEMP_MSB / HUM_MSB / ID - BME280 register addresses
//   read_cmd()  - builds the on-wire read command byte from an address
// -----------------------------------------------------------------------------
package bme_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_XFER     = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   localparam logic [7:0] READ_BIT  = 8'h80;

   localparam logic [7:0] PRESS_MSB = 8'hF7;
   localparam logic [7:0] TEMP_MSB  = 8'hFA;
   localparam logic [7:0] HUM_MSB   = 8'hFD;
   localparam logic [7:0] ID        = 8'hD0;

   function automatic logic [7:0] read_cmd(input logic [7:0] addr);
      return addr | READ_BIT;
   endfunction

endpackage

// File: rtl/spi_mode0_shifter.sv
// -----------------------------------------------------------------------------
// spi_mode0_shifter
// SPI mode-0 bit engine: half-period divider plus an 8-bit MOSI/MISO shifter.
//   i_clk, i_rst_n  - clock, synchronous active-low reset
//   i_clr           - holds the divider and bit counter at zero (sequencer idle)
//   i_xfer          - enables SCK toggling and shifting (data phase)
//   i_load          - loads i_load_byte into the transmit register, bit 7 first
//   i_miso          - serial data from the slave, sampled on SCK rising edges
//   o_tick          - last cycle of a half-period; also times the CS phases
//   o_sck / o_mosi  - SPI clock (idle low) and serial data to the slave
//   o_byte_done     - one-cycle strobe on the falling edge ending bit 0 of a byte
//   o_rx_byte       - received byte, valid while o_byte_done is high
// -----------------------------------------------------------------------------
module spi_mode0_shifter #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_xfer,
   input  logic       i_load,
   input  logic [7:0] i_load_byte,
   input  logic       i_miso,
   output logic       o_tick,
   output logic       o_sck,
   output logic       o_mosi,
   output logic       o_byte_done,
   output logic [7:0] o_rx_byte
);

   localparam int unsigned   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic          r_sck;
   logic [2:0]    r_bit;
   logic [7:0]    r_tx;
   logic [7:0]    r_rx;

   logic w_tick;

   assign w_tick = (r_div == DIV_MAX);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_div <= '0;
      end else if (i_clr || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // MOSI is the MSB of the transmit register, so it only moves when the
   // register shifts on a falling SCK edge. Shifting in zeros naturally
   // produces the all-zero dummy bytes that follow the address.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sck <= 1'b0;
         r_bit <= 3'd0;
         r_tx  <= 8'h00;
         r_rx  <= 8'h00;
      end else if (i_load) begin
         r_sck <= 1'b0;
         r_bit <= 3'd0;
         r_tx  <= i_load_byte;
      end else if (i_clr) begin
         r_sck <= 1'b0;
         r_bit <= 3'd0;
      end else if (i_xfer && w_tick) begin
         if (!r_sck) begin
            r_sck <= 1'b1;
            r_rx  <= {r_rx[6:0], i_miso};
         end else begin
            r_sck <= 1'b0;
            r_tx  <= {r_tx[6:0], 1'b0};
            r_bit <= r_bit + 3'd1;
         end
      end
   end

   assign o_tick      = w_tick;
   assign o_sck       = r_sck;
   assign o_mosi      = r_tx[7];
   assign o_byte_done = i_xfer && w_tick && r_sck && (r_bit == 3'd7);
   assign o_rx_byte   = r_rx;

endmodule

// File: rtl/bme_burst_reader.sv
// -----------------------------------------------------------------------------
// bme_burst_reader
// SPI master that reads N_BYTES consecutive BME280 registers starting at
// START_ADDR and hands each burst to the host through a holding register.
//   CLOCK_50, reset_reset_n - clock, synchronous active-low reset
//   start                   - one-cycle trigger request
//   busy                    - a burst (including the trailing CS gap) is running
//   sample_data             - last captured burst, first byte in the MSBs
//   sample_valid            - holding register full
//   sample_ready            - consumer accepts the sample
//   overrun                 - sticky: an unread sample was overwritten
//   bme_csn/sck/mosi/miso   - SPI mode-0 pins
//   o_dbg_state             - current sequencer state (state_t encoding)
//
// Handshake: a sample transfers in every cycle where sample_valid and
// sample_ready are both high; sample_valid never drops without that transfer
// unless reset. A new burst landing while the sample is unaccepted replaces it
// and sets overrun; overrun clears on the next completed transfer.
// -----------------------------------------------------------------------------
module bme_burst_reader
   import bme_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 25,
   parameter int unsigned N_BYTES       = 8,
   parameter logic [7:0]  START_ADDR    = 8'hF7,
   parameter int unsigned PERIOD_CYCLES = 50000000
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_reset_n,
   input  logic                 start,
   output logic                 busy,
   output logic [N_BYTES*8-1:0] sample_data,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic                 overrun,
   output logic                 bme_csn,
   output logic                 bme_sck,
   output logic                 bme_mosi,
   input  logic                 bme_miso,
   output logic [2:0]           o_dbg_state
);

   localparam int unsigned   SW        = N_BYTES * 8;
   localparam int unsigned   BW        = $clog2(N_BYTES + 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES);

   state_t        r_state;
   state_t        w_next;
   logic          r_pending;
   logic [BW-1:0] r_byte_cnt;
   logic [SW-1:0] r_shift;
   logic [SW-1:0] r_data;
   logic          r_valid;
   logic          r_overrun;

   logic          w_timer_tick;
   logic          w_trig;
   logic          w_accept;
   logic          w_spi_tick;
   logic          w_byte_done;
   logic [7:0]    w_rx_byte;
   logic          w_last_byte;
   logic          w_load;
   logic          w_hs;

   // ---------------------------------------------------------------- timer
   if (PERIOD_CYCLES == 0) begin : g_no_timer
      assign w_timer_tick = 1'b0;
   end else begin : g_timer
      localparam int unsigned   TW    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
      localparam logic [TW-1:0] T_MAX = TW'(PERIOD_CYCLES - 1);

      logic [TW-1:0] r_timer;

      always_ff @(posedge CLOCK_50) begin
         if (!reset_reset_n) begin
            r_timer <= '0;
         end else if (r_timer == T_MAX) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end

      assign w_timer_tick = (r_timer == T_MAX);
   end

   // ------------------------------------------------------------- triggers
   // start and a timer tick in the same cycle merge into one request.
   assign w_trig   = start || w_timer_tick;
   assign w_accept = (r_state == ST_IDLE) && (w_trig || r_pending);

   // One-deep queue for requests that arrive mid-burst; extras are dropped.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         r_pending <= 1'b0;
      end else if (w_accept) begin
         r_pending <= 1'b0;
      end else if ((r_state != ST_IDLE) && w_trig) begin
         r_pending <= 1'b1;
      end
   end

   // ------------------------------------------------------------ bit engine
   spi_mode0_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .i_clk       (CLOCK_50),
      .i_rst_n     (reset_reset_n),
      .i_clr       (r_state == ST_IDLE),
      .i_xfer      (r_state == ST_XFER),
      .i_load      (w_accept),
      .i_load_byte (read_cmd(START_ADDR)),
      .i_miso      (bme_miso),
      .o_tick      (w_spi_tick),
      .o_sck       (bme_sck),
      .o_mosi      (bme_mosi),
      .o_byte_done (w_byte_done),
      .o_rx_byte   (w_rx_byte)
   );

   // Byte 0 is the address phase; bytes 1..N_BYTES carry data.
   assign w_last_byte = w_byte_done && (r_byte_cnt == LAST_BYTE);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         r_byte_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_byte_cnt <= '0;
      end else if (w_byte_done) begin
         r_byte_cnt <= r_byte_cnt + 1'b1;
      end
   end

   // MISO bytes seen during the address phase are discarded.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         r_shift <= '0;
      end else if (w_byte_done && (r_byte_cnt != '0)) begin
         r_shift <= (r_shift << 8) | SW'(w_rx_byte);
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept)    w_next = ST_CS_SETUP;
         ST_CS_SETUP: if (w_spi_tick)  w_next = ST_XFER;
         ST_XFER:     if (w_last_byte) w_next = ST_CS_HOLD;
         ST_CS_HOLD:  if (w_spi_tick)  w_next = ST_GAP;
         ST_GAP:      if (w_spi_tick)  w_next = ST_IDLE;
         default:                      w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bme_csn = 1'b1;
      busy    = 1'b1;
      case (r_state)
         ST_IDLE:     busy    = 1'b0;
         ST_CS_SETUP: bme_csn = 1'b0;
         ST_XFER:     bme_csn = 1'b0;
         ST_CS_HOLD:  bme_csn = 1'b0;
         ST_GAP:      bme_csn = 1'b1;
         default: begin
            bme_csn = 1'b1;
            busy    = 1'b0;
         end
      endcase
   end

   assign o_dbg_state = r_state;

   // ------------------------------------------------------- holding register
   assign w_load = (r_state == ST_CS_HOLD) && w_spi_tick;
   assign w_hs   = r_valid && sample_ready;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end

         // A load coinciding with a transfer is an ordinary load.
         if (w_load && r_valid && !sample_ready) begin
            r_overrun <= 1'b1;
         end else if (w_hs) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign sample_data  = r_data;
   assign sample_valid = r_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_bme_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_bme_burst_reader
// Bench for bme_burst_reader (CLK_DIV=2, N_BYTES=8). A second instance with a
// 1000-cycle timer checks periodic triggering. A behavioural BME280 slave
// serves one queued 72-bit frame per chip-select and captures MOSI; sample
// handshakes are compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_bme_burst_reader;

   localparam int CLK_DIV = 2;
   localparam int N_BYTES = 8;

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic        ready   = 1'b0;
   logic        miso    = 1'b0;
   logic        busy;
   logic [63:0] sdata;
   logic        svalid;
   logic        ovr;
   logic        bme_csn;
   logic        bme_sck;
   logic        bme_mosi;
   logic [2:0]  dbg_state;

   logic        rst_p   = 1'b0;
   logic        start_p = 1'b0;
   logic        ready_p = 1'b1;
   logic        miso_p  = 1'b0;
   logic        busy_p;
   logic [63:0] sdata_p;
   logic        svalid_p;
   logic        ovr_p;
   logic        csn_p;
   logic        sck_p;
   logic        mosi_p;
   logic [2:0]  dbg_state_p;

   bme_burst_reader #(
      .CLK_DIV (CLK_DIV), .N_BYTES (N_BYTES), .START_ADDR (8'hF7), .PERIOD_CYCLES (0)
   ) u_dut (
      .CLOCK_50 (clk), .reset_reset_n (rst_n), .start (start), .busy (busy),
      .sample_data (sdata), .sample_valid (svalid), .sample_ready (ready),
      .overrun (ovr), .bme_csn (bme_csn), .bme_sck (bme_sck), .bme_mosi (bme_mosi),
      .bme_miso (miso), .o_dbg_state (dbg_state)
   );

   bme_burst_reader #(
      .CLK_DIV (CLK_DIV), .N_BYTES (N_BYTES), .START_ADDR (8'hF7), .PERIOD_CYCLES (1000)
   ) u_per (
      .CLOCK_50 (clk), .reset_reset_n (rst_p), .start (start_p), .busy (busy_p),
      .sample_data (sdata_p), .sample_valid (svalid_p), .sample_ready (ready_p),
      .overrun (ovr_p), .bme_csn (csn_p), .bme_sck (sck_p), .bme_mosi (mosi_p),
      .bme_miso (miso_p), .o_dbg_state (dbg_state_p)
   );

   // ------------------------------------------------------- bookkeeping
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   logic [71:0] frame_q[$];
   int          fall_q[$];
   int          pfall_q[$];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queues the slave's frame (random address-phase byte, then data) and,
   // when the sample is expected to reach the consumer, its expected value.
   task automatic issue(input logic [63:0] data, input bit expect_sample);
      logic [7:0] junk;
      junk = 8'($urandom);
      frame_q.push_back({junk, data});
      if (expect_sample) exp_q.push_back(data);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // sel 0: wait for sample_valid high; sel 1: wait for busy low.
   task automatic wait_for(input int sel, input int budget, input string name, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if ((sel == 0 && svalid === 1'b1) || (sel == 1 && busy === 1'b0)) begin
            at = cyc;
            break;
         end
         tick();
      end
      if (at < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: timeout, no event within %0d cycles", name, budget);
      end
   endtask

   // ---------------------------------------------------- BME280 slave model
   logic [71:0] cur_frame = '0;
   logic [71:0] mosi_cap  = '0;
   int          bit_k     = 0;
   int          rises     = 0;
   logic        csn_prev  = 1'b1;
   logic        sck_prev  = 1'b0;

   always @(negedge clk) begin
      if (csn_prev === 1'b1 && bme_csn === 1'b0) begin
         fall_q.push_back(cyc);
         if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
         else cur_frame = {$urandom, $urandom, 8'h5A};
         bit_k    = 0;
         rises    = 0;
         mosi_cap = '0;
         miso     = cur_frame[71];
         check("sck_idle_at_cs_fall", 72'(bme_sck), 72'(0));
      end
      if (csn_prev === 1'b0 && bme_csn === 1'b1 && rst_n === 1'b1) begin
         check("sck_rise_count", 72'(rises), 72'(72));
         check("mosi_frame", mosi_cap, {8'hF7, 64'h0});
         check("sck_idle_at_cs_rise", 72'(bme_sck), 72'(0));
      end
      if (bme_csn === 1'b0 && sck_prev === 1'b0 && bme_sck === 1'b1) begin
         rises++;
         mosi_cap = {mosi_cap[70:0], bme_mosi};
      end
      if (bme_csn === 1'b0 && sck_prev === 1'b1 && bme_sck === 1'b0 && bit_k < 71) begin
         bit_k++;
         miso = cur_frame[71 - bit_k];
      end
      csn_prev = bme_csn;
      sck_prev = bme_sck;
   end

   logic pcsn_prev = 1'b1;
   always @(negedge clk) begin
      if (pcsn_prev === 1'b1 && csn_p === 1'b0) pfall_q.push_back(cyc);
      pcsn_prev = csn_p;
   end

   // ------------------------------------------------------------ scoreboard
   always @(negedge clk) begin
      if (rst_n === 1'b1 && svalid === 1'b1 && ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_sample: got %0h, required no sample", sdata);
         end else begin
            check("sample_data", 72'(sdata), 72'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      int          c0;
      int          at;
      int          nf0;
      int          rp;
      logic [63:0] d;

      // Reset with random inputs
      repeat (2) begin
         start = 1'($urandom_range(0, 1));
         ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("rst_csn",    72'(bme_csn),  72'(1));
      check("rst_sck",    72'(bme_sck),  72'(0));
      check("rst_mosi",   72'(bme_mosi), 72'(0));
      check("rst_busy",   72'(busy),     72'(0));
      check("rst_valid",  72'(svalid),   72'(0));
      check("rst_data",   72'(sdata),    72'(0));
      check("rst_overrun",72'(ovr),      72'(0));
      start = 1'b0;
      ready = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();

      // Single read: latency of valid and busy
      issue(64'h1122334455667788, 1'b1);
      c0 = cyc;
      pulse_start();
      wait_for(0, 400, "single_valid", at);
      check("valid_latency", 72'(at - c0), 72'(293));
      check("single_data", 72'(sdata), 72'(64'h1122334455667788));
      wait_for(1, 50, "single_busy", at);
      check("busy_fall_latency", 72'(at - c0), 72'(295));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("valid_clear", 72'(svalid), 72'(0));

      // Backpressure: second burst overwrites unread first one
      d = {$urandom, $urandom};
      issue(d, 1'b0);
      pulse_start();
      wait_for(1, 400, "bp_first_busy", at);
      issue(64'hA1A2A3A4A5A6A7A8, 1'b1);
      pulse_start();
      wait_for(1, 400, "bp_second_busy", at);
      check("bp_data",    72'(sdata),  72'(64'hA1A2A3A4A5A6A7A8));
      check("bp_valid",   72'(svalid), 72'(1));
      check("bp_overrun", 72'(ovr),    72'(1));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("bp_valid_clear",   72'(svalid), 72'(0));
      check("bp_overrun_clear", 72'(ovr),    72'(0));

      // Trigger queueing: three requests, two bursts
      ready = 1'b1;
      issue({$urandom, $urandom}, 1'b1);
      issue({$urandom, $urandom}, 1'b1);
      nf0 = fall_q.size();
      c0 = cyc;
      pulse_start();
      repeat (49) tick();
      pulse_start();
      repeat (49) tick();
      pulse_start();
      repeat (800) tick();
      check("queue_bursts", 72'(fall_q.size() - nf0), 72'(2));
      if (fall_q.size() - nf0 >= 2) begin
         check("queue_first_cs",  72'(fall_q[nf0] - c0), 72'(1));
         check("queue_second_cs", 72'(fall_q[nf0 + 1] - fall_q[nf0]), 72'(295));
      end
      ready = 1'b0;

      // Periodic trigger on the timer instance, start merged with a tick
      rp = cyc;
      rst_p = 1'b1;
      while (cyc < rp + 1999) tick();
      start_p = 1'b1;
      tick();
      start_p = 1'b0;
      while (cyc < rp + 5100) tick();
      check("periodic_bursts", 72'(pfall_q.size()), 72'(5));
      for (int i = 0; i < pfall_q.size() && i < 5; i++)
         check("periodic_cs_cycle", 72'(pfall_q[i] - rp), 72'(1000 * (i + 1)));
      rst_p = 1'b0;

      // Abort by reset mid-burst, then a clean burst
      ready = 1'b1;
      issue({$urandom, $urandom}, 1'b0);
      c0 = cyc;
      pulse_start();
      repeat (99) tick();
      rst_n = 1'b0;
      tick();
      check("abort_csn",  72'(bme_csn), 72'(1));
      check("abort_sck",  72'(bme_sck), 72'(0));
      check("abort_busy", 72'(busy),    72'(0));
      tick();
      rst_n = 1'b1;
      repeat (350) tick();
      check("abort_no_valid", 72'(svalid), 72'(0));
      d = {$urandom, $urandom};
      issue(d, 1'b1);
      c0 = cyc;
      pulse_start();
      wait_for(0, 400, "post_abort_valid", at);
      check("post_abort_latency", 72'(at - c0), 72'(293));
      wait_for(1, 50, "post_abort_busy", at);
      repeat (3) tick();

      // Random data with random backpressure
      for (int n = 0; n < 4; n++) begin
         issue({$urandom, $urandom}, 1'b1);
         pulse_start();
         repeat (300) begin
            ready = 1'($urandom_range(0, 1));
            tick();
         end
         ready = 1'b1;
         repeat (3) tick();
      end

      check("exp_q_drained", 72'(exp_q.size()), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bme_burst_reader.md
Name: bme_burst_reader

Overview:
- Hardware SPI master that reads a burst of raw measurement registers from the BME280 sensor and passes each completed sample to the Nios II system through a valid/ready holding register.
- Sits between the BME_* board pins and a Nios-side PIO/Avalon adapter, replacing software bit-banging of the sensor.
- Triggers are an explicit start pulse or an internal periodic timer.

Parameters:
- CLK_DIV, 25, CLOCK_50 cycles per SCK half-period (25 gives 1 MHz SCK); must be ≥ 2.
- N_BYTES, 8, data bytes read per burst.
- START_ADDR, 8'hF7, first register address; bit 7 is forced to 1 on the wire (read).
- PERIOD_CYCLES, 50000000, auto-trigger interval in clock cycles; 0 disables the timer.

Ports:
- CLOCK_50  in  1  system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle trigger request.
- busy  out  1  high from the cycle after a trigger is accepted through the end of the idle gap.
- sample_data  out  N_BYTES*8  captured burst; first received byte in the MSBs.
- sample_valid  out  1  holding register is full.
- sample_ready  in  1  consumer accepts the sample when sample_valid is also high.
- overrun  out  1  sticky flag: an unread sample was overwritten.
- bme_csn  out  1  chip select, active low.
- bme_sck  out  1  SPI clock, mode 0.
- bme_mosi  out  1  master out.
- bme_miso  in  1  master in.

Behaviour:
- Reset (synchronous, active low): bme_csn=1, bme_sck=0, bme_mosi=0, busy=0, sample_valid=0, sample_data=0, overrun=0, timer=0, pending=0, state=IDLE.
- Reset asserted mid-transfer aborts it: bme_csn goes high on the next clock edge and no sample is produced.
- FSM states: IDLE, CS_SETUP, XFER, CS_HOLD, GAP.
  - IDLE: on trigger (start, timer tick, or pending), go to CS_SETUP, drive bme_csn=0, busy=1, and put MOSI bit 7 of (START_ADDR|8'h80) on bme_mosi.
  - CS_SETUP: lasts CLK_DIV cycles, SCK low.
  - XFER: (1+N_BYTES)*8 bits, each bit 2*CLK_DIV cycles. SCK rises after the first CLK_DIV cycles and MISO is sampled on that rising edge. SCK falls after the second CLK_DIV cycles and the next MOSI bit is driven on that falling edge. Bits go out MSB first.
  - MOSI sequence: the address byte, then N_BYTES of 8'h00. MISO bits received during the address byte are discarded.
  - CS_HOLD: CLK_DIV cycles with SCK low. On exit, bme_csn=1 and the shift register loads into the holding register.
  - GAP: CLK_DIV cycles with bme_csn high, then return to IDLE with busy=0.
- Latency: sample_valid rises 1+(2+16*(1+N_BYTES))*CLK_DIV cycles after the cycle in which start is sampled. busy falls CLK_DIV cycles after that.
- Trigger arbitration: a start or timer tick while not IDLE sets pending, one deep; further triggers while pending is set are dropped. pending launches a transfer directly from IDLE and clears when it does.
- Timer: free-running while PERIOD_CYCLES≠0. It counts 0..PERIOD_CYCLES-1, ticks on wrap, and is unaffected by busy. Simultaneous start and tick count as one trigger.
- Holding register:
  - Handshake completes when sample_valid && sample_ready; sample_valid then clears next cycle unless a new load occurs in the same cycle.
  - A load while sample_valid && !sample_ready overwrites sample_data, keeps sample_valid high, and sets overrun.
  - A load in the same cycle as a handshake is a normal load with no overrun.
  - overrun clears on the next completed handshake.

Decomposition:
- Package bme_spi_pkg holds:
  - the state enum;
  - READ_BIT = 8'h80;
  - BME280 register constants: PRESS_MSB 8'hF7, TEMP_MSB 8'hFA, HUM_MSB 8'hFD, ID 8'hD0.
- Sub-module spi_mode0_shifter: half-period divider plus the 8-bit MOSI/MISO shift engine with byte_done. The top handles CSN sequencing, triggers, timer and holding register.

Test Plan (CLK_DIV=2, N_BYTES=8, PERIOD_CYCLES=0 unless noted):
1. Reset: drive reset_reset_n low for 2 cycles with random inputs → bme_csn=1, bme_sck=0, bme_mosi=0, busy=0, sample_valid=0, sample_data=0, overrun=0.
2. Single read: pulse start. MISO model returns 0x11,0x22,…,0x88.
   - MOSI decodes as 0xF7 followed by eight 0x00.
   - 72 SCK rising edges occur, with SCK idle low.
   - sample_data=64'h1122334455667788 and sample_valid rises exactly 293 cycles after start.
   - busy falls at cycle 295.
3. Backpressure: hold sample_ready=0 over two bursts (second returns 0xA1..0xA8) → sample_data=64'hA1A2…A8 and overrun=1. Assert ready for one cycle → sample_valid=0 and overrun=0.
4. Trigger queueing: pulse start at cycle 0, again at cycle 50, and again at 100 → exactly two bursts. The second has CSN falling 1 cycle after the first GAP ends. The third request is dropped.
5. Periodic: PERIOD_CYCLES=1000, run 5000 cycles → 5 bursts, CSN falls at cycles 1000, 2000, …; concurrent start at cycle 2000 yields only one burst.
6. Abort: assert reset at cycle 100 of a burst → bme_csn=1 at the next edge, no sample_valid, and the next start produces a full correct burst.
